sprite_engine: RTL and testbench

//  Next-generation sprite source: one sprite per instance, integer scaling (1x/2x/4x/8x), H/V flip, and
//  req/ack handshake to the pixel arbiter. Per-pixel multiply replaced by incremental address counters.

---
 rtl/sprite_engine.sv | 171 +++++++++++++++++
 tb/tb_sprite_engine.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_engine.sv
// Single-sprite pixel source: integer scaling, H/V flip and a req/ack handshake towards the pixel arbiter.
// Texel addresses come from incremental row/column counters; one registered multiply per frame seeds the row base.
module sprite_engine #(
  parameter int ram_add_width = 8,
  parameter int POS_W         = 10,
  parameter int SCALE_W       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clk25en,
  input  logic                     sprite_enable,
  input  logic [POS_W-1:0]         x_pos,
  input  logic [POS_W-1:0]         y_pos,
  input  logic [POS_W-1:0]         width,
  input  logic [POS_W-1:0]         height,
  input  logic [SCALE_W-1:0]       scale_log2,
  input  logic                     flip_h,
  input  logic                     flip_v,
  input  logic [ram_add_width-1:0] address_in,
  input  logic [1:0]               layer_in,
  input  logic [POS_W-1:0]         curr_x_pos,
  input  logic [POS_W-1:0]         curr_y_pos,
  input  logic                     blank,
  input  logic                     ack,
  output logic [1:0]               layer_out,
  output logic [ram_add_width-1:0] address_out,
  output logic                     request,
  output logic                     miss,
  output logic [7:0]               miss_count
);

  localparam int AW    = ram_add_width;
  localparam int SUB_W = (1 << SCALE_W) - 1;
  localparam int EXT_W = POS_W + SUB_W + 1;
  localparam logic [POS_W-1:0] POS_MAX = '1;

  typedef enum logic [1:0] {IDLE, ARMED, ACTIVE, DONE} state_t;

  // Last covered coordinate of a scaled span, clipped to the screen edge instead of wrapping.
  function automatic logic [POS_W-1:0] span_end(input logic [POS_W-1:0]   base,
                                                input logic [POS_W-1:0]   size,
                                                input logic [SCALE_W-1:0] s);
    logic [EXT_W-1:0] full;
    full = EXT_W'(base) + (EXT_W'(size) << s) - EXT_W'(1);
    return (full > EXT_W'(POS_MAX)) ? POS_MAX : full[POS_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [POS_W-1:0]  sh_x_q, sh_x_d, sh_y_q, sh_y_d, sh_w_q, sh_w_d, sh_h_q, sh_h_d;
  logic [POS_W-1:0]  x_end_q, x_end_d, y_end_q, y_end_d;
  logic [SCALE_W-1:0] sh_s_q, sh_s_d;
  logic              sh_fh_q, sh_fh_d, sh_fv_q, sh_fv_d;
  logic [AW-1:0]     sh_addr_q, sh_addr_d;
  logic [1:0]        layer_q, layer_d;
  logic              calc_q, calc_d;
  logic [AW-1:0]     row_base_q, row_base_d;
  logic [SUB_W-1:0]  subrow_q, subrow_d, subcol_q, subcol_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic              request_q, request_d, miss_q, miss_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [7:0]        miss_count_q, miss_count_d;

  logic              latch, line_start, live, in_x, in_y, slot, row_evt;
  logic [SUB_W-1:0]  sub_max, subcol_cur;
  logic [POS_W-1:0]  col_cur, texel;
  logic [AW-1:0]     prod, row_base_cur;

  always_comb begin
    latch      = clk25en && (curr_x_pos == '0) && (curr_y_pos == '0);
    line_start = clk25en && (curr_x_pos == '0);
    live       = (state_q == ARMED) || (state_q == ACTIVE);
    in_x       = (curr_x_pos >= sh_x_q) && (curr_x_pos <= x_end_q);
    in_y       = (curr_y_pos >= sh_y_q) && (curr_y_pos <= y_end_q);
    slot       = clk25en && !latch && live && !blank && in_x && in_y;
    row_evt    = line_start && !latch && live && (curr_y_pos > sh_y_q) && (curr_y_pos <= y_end_q);
    sub_max    = ~({SUB_W{1'b1}} << sh_s_q);
    prod       = AW'(sh_h_q - POS_W'(1)) * AW'(sh_w_q);

    sh_x_d    = sh_x_q;    sh_y_d  = sh_y_q;  sh_w_d  = sh_w_q;  sh_h_d = sh_h_q;
    sh_s_d    = sh_s_q;    sh_fh_d = sh_fh_q; sh_fv_d = sh_fv_q;
    sh_addr_d = sh_addr_q; layer_d = layer_q; x_end_d = x_end_q; y_end_d = y_end_q;
    calc_d    = latch;
    if (latch) begin
      sh_x_d    = x_pos;      sh_y_d  = y_pos;  sh_w_d  = width;  sh_h_d = height;
      sh_s_d    = scale_log2; sh_fh_d = flip_h; sh_fv_d = flip_v;
      sh_addr_d = address_in; layer_d = layer_in;
      x_end_d   = span_end(x_pos, width, scale_log2);
      y_end_d   = span_end(y_pos, height, scale_log2);
    end

    // Each source row is repeated on 2^s screen lines before the base steps by one texel row.
    row_base_cur = row_base_q;
    subrow_d     = subrow_q;
    if (row_evt) begin
      if (subrow_q == sub_max) begin
        subrow_d     = '0;
        row_base_cur = sh_fv_q ? (row_base_q - AW'(sh_w_q)) : (row_base_q + AW'(sh_w_q));
      end else begin
        subrow_d = subrow_q + SUB_W'(1);
      end
    end
    if (latch) subrow_d = '0;
    row_base_d = calc_q ? (sh_addr_q + (sh_fv_q ? prod : '0)) : row_base_cur;

    col_cur    = line_start ? '0 : col_q;
    subcol_cur = line_start ? '0 : subcol_q;
    col_d      = col_cur;
    subcol_d   = subcol_cur;
    texel      = sh_fh_q ? (sh_w_q - POS_W'(1) - col_cur) : col_cur;
    if (slot) begin
      if (subcol_cur == sub_max) begin
        subcol_d = '0;
        col_d    = col_cur + POS_W'(1);
      end else begin
        subcol_d = subcol_cur + SUB_W'(1);
      end
    end

    // A request still pending at the next pixel tick expires; a new slot in that tick re-arms it.
    miss_d    = clk25en && request_q && !ack;
    request_d = request_q;
    addr_d    = addr_q;
    if (request_q && (ack || clk25en)) request_d = 1'b0;
    if (slot) begin
      request_d = 1'b1;
      addr_d    = row_base_cur + AW'(texel);
    end

    miss_count_d = miss_count_q;
    if (latch)                                  miss_count_d = '0;
    else if (miss_d && (miss_count_q != 8'hFF)) miss_count_d = miss_count_q + 8'd1;

    state_d = state_q;
    if (latch) begin
      state_d = (sprite_enable && (width != '0) && (height != '0)) ? ARMED : IDLE;
    end else begin
      case (state_q)
        ARMED:   if (slot) state_d = ACTIVE;
        ACTIVE:  if (line_start && (curr_y_pos > y_end_q)) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_x_q     <= '0; sh_y_q  <= '0; sh_w_q  <= '0; sh_h_q <= '0;
      sh_s_q     <= '0; sh_fh_q <= 1'b0; sh_fv_q <= 1'b0;
      sh_addr_q  <= '0; layer_q <= '0; x_end_q <= '0; y_end_q <= '0;
      calc_q     <= 1'b0;
      row_base_q <= '0; subrow_q <= '0; subcol_q <= '0; col_q <= '0;
      request_q  <= 1'b0; miss_q <= 1'b0; addr_q <= '0; miss_count_q <= '0;
    end else begin
      state_q    <= state_d;
      sh_x_q     <= sh_x_d; sh_y_q  <= sh_y_d;  sh_w_q  <= sh_w_d;  sh_h_q <= sh_h_d;
      sh_s_q     <= sh_s_d; sh_fh_q <= sh_fh_d; sh_fv_q <= sh_fv_d;
      sh_addr_q  <= sh_addr_d; layer_q <= layer_d; x_end_q <= x_end_d; y_end_q <= y_end_d;
      calc_q     <= calc_d;
      row_base_q <= row_base_d; subrow_q <= subrow_d; subcol_q <= subcol_d; col_q <= col_d;
      request_q  <= request_d; miss_q <= miss_d; addr_q <= addr_d; miss_count_q <= miss_count_d;
    end
  end

  assign layer_out   = layer_q;
  assign address_out = addr_q;
  assign request     = request_q;
  assign miss        = miss_q;
  assign miss_count  = miss_count_q;

endmodule

// File: tb/tb_sprite_engine.sv
// Self-checking bench for sprite_engine: sparse scan positions driven per pixel tick, checked against
// a texel-coordinate reference model (address = base + ty*width + tx from screen position).
module tb_sprite_engine;

  localparam int AW = 8;
  localparam int PW = 10;
  localparam int SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clk25en, sprite_enable, flip_h, flip_v, blank, ack;
  logic [PW-1:0] x_pos, y_pos, width, height, curr_x_pos, curr_y_pos;
  logic [SW-1:0] scale_log2;
  logic [AW-1:0] address_in, address_out;
  logic [1:0]    layer_in, layer_out;
  logic          request, miss;
  logic [7:0]    miss_count;

  sprite_engine #(.ram_add_width(AW), .POS_W(PW), .SCALE_W(SW)) dut (
    .clk(clk), .rst(rst), .clk25en(clk25en), .sprite_enable(sprite_enable),
    .x_pos(x_pos), .y_pos(y_pos), .width(width), .height(height), .scale_log2(scale_log2),
    .flip_h(flip_h), .flip_v(flip_v), .address_in(address_in), .layer_in(layer_in),
    .curr_x_pos(curr_x_pos), .curr_y_pos(curr_y_pos), .blank(blank), .ack(ack),
    .layer_out(layer_out), .address_out(address_out), .request(request), .miss(miss),
    .miss_count(miss_count)
  );

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_armed = 0, m_fh = 0, m_fv = 0, m_pending = 0;
  int m_x = 0, m_y = 0, m_w = 0, m_h = 0, m_s = 0, m_addr = 0, m_layer = 0, m_misses = 0;
  int ack_mode = 0;  // 0 = always ack, 1 = never ack, 2 = random
  int seen[$];

  task automatic config_sprite(input int x, input int y, input int w, input int h, input int s,
                               input bit fh, input bit fv, input int addr, input int layer, input bit en);
    x_pos = PW'(x); y_pos = PW'(y); width = PW'(w); height = PW'(h); scale_log2 = SW'(s);
    flip_h = fh; flip_v = fv; address_in = AW'(addr); layer_in = 2'(layer); sprite_enable = en;
  endtask

  // One pixel time (4 clk): tick at the first edge, optional ack, then model update and checks.
  task automatic pixel(input int x, input int y);
    bit bl, latch, slot, exp_miss, give_ack;
    int xe, ye, tx, ty, ea;
    bl = (x >= 640) || (y >= 480);
    latch = (x == 0) && (y == 0);
    exp_miss = m_pending;
    slot = 0; ea = 0;
    if (!latch && m_armed && !bl) begin
      xe = m_x + (m_w << m_s) - 1; if (xe > 1023) xe = 1023;
      ye = m_y + (m_h << m_s) - 1; if (ye > 1023) ye = 1023;
      if (x >= m_x && x <= xe && y >= m_y && y <= ye) begin
        slot = 1;
        tx = (x - m_x) >> m_s;
        ty = (y - m_y) >> m_s;
        if (m_fh) tx = m_w - 1 - tx;
        if (m_fv) ty = m_h - 1 - ty;
        ea = (m_addr + ty * m_w + tx) % 256;
      end
    end
    curr_x_pos = PW'(x); curr_y_pos = PW'(y); blank = bl; clk25en = 1'b1;
    @(negedge clk);
    clk25en = 1'b0;
    if (exp_miss && m_misses < 255) m_misses++;
    if (latch) begin
      m_misses = 0;
      m_armed = sprite_enable && (width != 0) && (height != 0);
      m_x = int'(x_pos); m_y = int'(y_pos); m_w = int'(width); m_h = int'(height);
      m_s = int'(scale_log2); m_fh = flip_h; m_fv = flip_v;
      m_addr = int'(address_in); m_layer = int'(layer_in);
    end
    checks++;
    if (miss !== exp_miss) begin
      errors++; $display("[TB] FAIL miss_pulse (%0d,%0d): got %b want %b", x, y, miss, exp_miss);
    end
    checks++;
    if (miss_count !== 8'(m_misses)) begin
      errors++; $display("[TB] FAIL miss_count (%0d,%0d): got %0d want %0d", x, y, miss_count, m_misses);
    end
    checks++;
    if (request !== slot) begin
      errors++; $display("[TB] FAIL request (%0d,%0d): got %b want %b", x, y, request, slot);
    end
    if (slot) begin
      checks++;
      if (address_out !== AW'(ea)) begin
        errors++; $display("[TB] FAIL address (%0d,%0d): got %0h want %0h", x, y, address_out, ea);
      end
    end
    checks++;
    if (layer_out !== 2'(m_layer)) begin
      errors++; $display("[TB] FAIL layer (%0d,%0d): got %0d want %0d", x, y, layer_out, m_layer);
    end
    if (request === 1'b1) seen.push_back(int'(address_out));
    m_pending = 0;
    give_ack = slot && (ack_mode == 0 || (ack_mode == 2 && $urandom_range(1, 0) == 1));
    if (give_ack) ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    if (give_ack) begin
      checks++;
      if (request !== 1'b0) begin
        errors++; $display("[TB] FAIL ack_drop (%0d,%0d): got %b want 0", x, y, request);
      end
    end else if (slot) begin
      m_pending = 1;
      checks++;
      if (request !== 1'b1 || address_out !== AW'(ea)) begin
        errors++; $display("[TB] FAIL hold (%0d,%0d): got req=%b addr=%0h want req=1 addr=%0h",
                           x, y, request, address_out, ea);
      end
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  // Visits every footprint row (plus one margin row each side), each starting at x=0.
  task automatic scan_rows();
    int xs, xe, ys, ye;
    ys = (int'(y_pos) > 1) ? int'(y_pos) - 1 : 1;
    ye = int'(y_pos) + (int'(height) << scale_log2); if (ye > 1023) ye = 1023;
    xs = (int'(x_pos) > 1) ? int'(x_pos) - 1 : 1;
    xe = int'(x_pos) + (int'(width) << scale_log2); if (xe > 1023) xe = 1023;
    for (int y = ys; y <= ye; y++) begin
      pixel(0, y);
      for (int x = xs; x <= xe; x++) pixel(x, y);
    end
  endtask

  task automatic scan_frame();
    pixel(0, 0);
    scan_rows();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (request !== 1'b0 || miss !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_req_miss: got req=%b miss=%b want 0 0", request, miss);
    end
    checks++;
    if (miss_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_miss_count: got %0d want 0", miss_count);
    end
    checks++;
    if (address_out !== '0 || layer_out !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_addr_layer: got %0h/%0d want 0/0", address_out, layer_out);
    end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int exp_q[$];
    exp_q = '{16, 17, 18, 19, 20, 21, 22, 23};
    config_sprite(100, 50, 4, 2, 0, 0, 0, 16, 2, 1);
    ack_mode = 0; seen.delete();
    scan_frame();
    checks++;
    if (seen.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL basic_count: got %0d want %0d", seen.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (seen[i] != exp_q[i]) begin
          errors++; $display("[TB] FAIL basic_addr[%0d]: got %0h want %0h", i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_scale();
    int exp_q[$];
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++) exp_q.push_back(16 + (r / 2) * 4 + c / 2);
    config_sprite(100, 50, 4, 2, 1, 0, 0, 16, 1, 1);
    ack_mode = 0; seen.delete();
    scan_frame();
    checks++;
    if (seen.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL scale_count: got %0d want %0d", seen.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (seen[i] != exp_q[i]) begin
          errors++; $display("[TB] FAIL scale_addr[%0d]: got %0h want %0h", i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_flip();
    int exp_q[$];
    exp_q = '{7, 6, 5, 4, 3, 2, 1, 0};
    config_sprite(200, 20, 4, 2, 0, 1, 1, 0, 3, 1);
    ack_mode = 0; seen.delete();
    scan_frame();
    checks++;
    if (seen.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL flip_count: got %0d want %0d", seen.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (seen[i] != exp_q[i]) begin
          errors++; $display("[TB] FAIL flip_addr[%0d]: got %0h want %0h", i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_clip();
    int exp_q[$];
    exp_q = '{32, 33, 40, 41};
    config_sprite(638, 10, 8, 2, 0, 0, 0, 32, 0, 1);
    ack_mode = 0; seen.delete();
    scan_frame();
    checks++;
    if (seen.size() != exp_q.size()) begin
      errors++; $display("[TB] FAIL clip_count: got %0d want %0d", seen.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (seen[i] != exp_q[i]) begin
          errors++; $display("[TB] FAIL clip_addr[%0d]: got %0h want %0h", i, seen[i], exp_q[i]);
        end
      end
    end
  endtask

  task automatic test_miss_saturation();
    config_sprite(10, 5, 64, 5, 0, 0, 0, 0, 1, 1);
    ack_mode = 1;
    scan_frame();
    checks++;
    if (miss_count !== 8'd255) begin
      errors++; $display("[TB] FAIL miss_saturate: got %0d want 255", miss_count);
    end
    pixel(0, 0);
    checks++;
    if (miss_count !== 8'd0) begin
      errors++; $display("[TB] FAIL miss_clear: got %0d want 0", miss_count);
    end
  endtask

  task automatic test_enable_midframe();
    config_sprite(30, 4, 3, 2, 0, 0, 0, 64, 2, 0);
    ack_mode = 0;
    pixel(0, 0);
    sprite_enable = 1'b1;
    seen.delete();
    scan_rows();
    checks++;
    if (seen.size() != 0) begin
      errors++; $display("[TB] FAIL enable_midframe: got %0d requests want 0", seen.size());
    end
    seen.delete();
    scan_frame();
    checks++;
    if (seen.size() != 6) begin
      errors++; $display("[TB] FAIL enable_nextframe: got %0d requests want 6", seen.size());
    end
  endtask

  task automatic test_reset_midrow();
    config_sprite(20, 3, 4, 2, 0, 0, 0, 8, 3, 1);
    ack_mode = 1;
    pixel(0, 0);
    pixel(0, 3);
    pixel(19, 3);
    pixel(20, 3);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (request !== 1'b0 || miss !== 1'b0 || miss_count !== 8'd0) begin
      errors++; $display("[TB] FAIL reset_midrow: got req=%b miss=%b cnt=%0d want 0 0 0",
                         request, miss, miss_count);
    end
    rst = 1'b0;
    m_armed = 0; m_pending = 0; m_misses = 0; m_layer = 0;
    seen.delete();
    scan_rows();
    checks++;
    if (seen.size() != 0) begin
      errors++; $display("[TB] FAIL reset_no_requests: got %0d requests want 0", seen.size());
    end
  endtask

  task automatic test_random();
    int s, w, h;
    ack_mode = 2;
    for (int f = 0; f < 6; f++) begin
      s = int'($urandom_range(3, 0));
      w = (s == 3) ? int'($urandom_range(4, 1)) : int'($urandom_range(8, 1));
      h = (s == 3) ? int'($urandom_range(2, 1)) : int'($urandom_range(4, 1));
      config_sprite(int'($urandom_range(650, 0)), int'($urandom_range(30, 1)), w, h, s,
                    1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                    int'($urandom_range(255, 0)), int'($urandom_range(3, 0)),
                    $urandom_range(3, 0) != 0);
      scan_frame();
    end
  endtask

  initial begin
    rst = 1'b1; clk25en = 1'b0; ack = 1'b0; blank = 1'b1;
    curr_x_pos = '0; curr_y_pos = '0;
    config_sprite(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_basic();
    test_scale();
    test_flip();
    test_clip();
    test_miss_saturation();
    test_enable_midframe();
    test_reset_midrow();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
